cu_issue_sequencer: RTL
=======================

Name: cu_issue_sequencer

Overview:
Instruction issue controller in front of tt_um_himanshu5_prog_computeUnit.
- Assembles 16-bit instructions from a byte-wide input stream and queues them in a small FIFO.
- Issues queued instructions to the compute unit one at a time and captures each write-back result.
- Bridges the 8-bit pin interface to the 16-bit compute unit instruction port.

Parameters:
DEPTH, 8, instruction FIFO entries (power of 2, 2..16)
CW, 4, width of occupancy count (log2(DEPTH)+1)

Ports:
clk  in  1  clock
rstn  in  1  asynchronous active-low reset
byte_in  in  8  instruction byte; high byte first, then low byte
byte_valid  in  1  byte_in valid this cycle
byte_ready  out  1  byte accepted when byte_valid && byte_ready
run  in  1  level; 1 = issue from FIFO, 0 = pause after current instruction
cu_instruction  out  16  instruction to compute unit
cu_en  out  1  compute unit enable, 1-cycle pulse per issue
cu_data  in  8  compute unit result data
cu_data_valid  in  1  compute unit result valid
cu_reg_id  in  4  compute unit target register
result_data  out  8  captured result
result_reg  out  4  captured target register
result_valid  out  1  1-cycle pulse per captured result
busy  out  1  FSM not in IDLE, or FIFO non-empty
count  out  CW  FIFO occupancy
retired  out  8  count of issued instructions, wraps 255->0

Behaviour:
- Reset (async, rstn=0):
  - All outputs go to 0, FIFO is emptied, byte phase returns to HIGH, FSM goes to IDLE.
  - Reset mid-issue drops the in-flight instruction; no result_valid is produced for it.
- Byte assembler:
  - Phase HIGH: an accepted byte is latched into hold[15:8] and phase becomes LOW.
  - Phase LOW: an accepted byte forms {hold, byte_in}, which is pushed into the FIFO that cycle; phase returns to HIGH.
  - byte_ready = !(phase==LOW && FIFO full). A high byte is always accepted; only the completing low byte stalls.
- FIFO:
  - Circular read/write pointers wrap modulo DEPTH.
  - Push and pop in the same cycle leaves count unchanged.
  - Pop on empty never occurs.
- FSM states: IDLE, ISSUE, WAIT.
  - IDLE -> ISSUE when run && count!=0.
  - ISSUE (1 cycle):
    - cu_instruction <= FIFO head.
    - cu_en = 1 for exactly this cycle; pop the FIFO; retired increments.
    - Then go to WAIT.
  - WAIT (1 cycle):
    - The compute unit has registered its result on the ISSUE edge, so the result is sampled here.
    - If cu_data_valid: result_data <= cu_data, result_reg <= cu_reg_id, result_valid = 1 on the next cycle.
    - Then go to ISSUE if run && count!=0, else IDLE.
- Throughput and latency:
  - Peak throughput is one instruction per 2 cycles. This spacing avoids read-after-write hazards in the compute unit register file.
  - Latency from entering ISSUE to the result_valid pulse is 2 cycles.
- cu_instruction holds its last value outside ISSUE; cu_en is 0 outside ISSUE.
- Dropping run takes effect at the next IDLE/ISSUE decision; an instruction already issued always completes WAIT.
- No-op (opcode 0) instructions are issued and retired; cu_data_valid stays low, so no result pulse is produced.

Optional Feature:
HALT_OPCODE_EN
- Defined:
  - A FIFO head with opcode 4'hF is popped in ISSUE but not driven to the compute unit (cu_en stays 0) and does not increment retired.
  - FSM enters a 4th state, HALTED; busy = 1 in HALTED.
  - HALTED is left to IDLE only when a rising edge of run is seen (run 0 then 1).
- Undefined: opcode 4'hF is issued like any other instruction (the compute unit treats it as a no-op); there is no HALTED state.

Test Plan:
- Bytes 13 05 14 02 25 34, run=1 -> result (reg,data) = (3,05), (4,02), (5,07) on consecutive 2-cycle slots; retired=3; busy drops afterwards.
- run=0, push DEPTH=8 instructions, then one extra high byte plus a low byte -> high byte accepted, byte_ready=0 on the low byte, count=8; raising run drains the FIFO and the pending low byte is accepted once count<8.
- Push 0000 then 1107 -> cu_en pulses twice, one result_valid only, (1,07); retired=2.
- Assert rstn=0 during WAIT of an ADD -> result_valid never pulses, count=0, retired=0, phase HIGH (next byte is treated as a high byte).
- 256 no-op issues -> retired wraps to 0; FIFO pointer wrap exercised with interleaved push/pop, order preserved.
- HALT_OPCODE_EN: 1301 F000 1402 -> (3,01), then HALTED with count=1; toggle run 0->1 -> (4,02); retired=2.

Source files
------------

// File: rtl/cu_issue_sequencer_if.sv
// Signal bundle between cu_issue_sequencer, its byte-wide pin side and the compute unit.
// master = pin driver / compute unit side, slave = the sequencer itself.
interface cu_issue_sequencer_if #(
  parameter int CW = 4
);
  logic [7:0]    byte_in;
  logic          byte_valid;
  logic          byte_ready;
  logic          run;
  logic [15:0]   cu_instruction;
  logic          cu_en;
  logic [7:0]    cu_data;
  logic          cu_data_valid;
  logic [3:0]    cu_reg_id;
  logic [7:0]    result_data;
  logic [3:0]    result_reg;
  logic          result_valid;
  logic          busy;
  logic [CW-1:0] count;
  logic [7:0]    retired;

  modport master (
    output byte_in, byte_valid, run, cu_data, cu_data_valid, cu_reg_id,
    input  byte_ready, cu_instruction, cu_en, result_data, result_reg,
           result_valid, busy, count, retired
  );

  modport slave (
    input  byte_in, byte_valid, run, cu_data, cu_data_valid, cu_reg_id,
    output byte_ready, cu_instruction, cu_en, result_data, result_reg,
           result_valid, busy, count, retired
  );
endinterface

// File: rtl/cu_issue_sequencer.sv
// Byte-to-instruction assembler, instruction FIFO and ISSUE/WAIT sequencer for the compute unit.
// Optional macro HALT_OPCODE_EN: opcode 4'hF parks the sequencer in HALTED until run rises again.
module cu_issue_sequencer #(
  parameter int DEPTH = 8,
  parameter int CW    = 4
) (
  input logic                 clk,
  input logic                 rstn,
  cu_issue_sequencer_if.slave bus
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

`ifdef HALT_OPCODE_EN
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, HALTED} state_t;
`else
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;
`endif
  typedef enum logic {PH_HIGH, PH_LOW} phase_t;

  state_t        state, next_state;
  phase_t        phase;
  logic [7:0]    hold;
  logic [15:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic [15:0]   head;
  logic          full, empty, accept, push, pop;
  logic          load_instr, issue_en, capture, skip_head;
  logic [15:0]   cu_instruction;
  logic [7:0]    retired;
  logic [7:0]    result_data;
  logic [3:0]    result_reg;
  logic          result_valid;

  assign head  = mem[rd_ptr];
  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);

  // Only the completing low byte can stall; a high byte just fills the holding register.
  assign bus.byte_ready = rstn && !(phase == PH_LOW && full);
  assign accept         = bus.byte_valid && bus.byte_ready;
  assign push           = accept && (phase == PH_LOW);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      phase <= PH_HIGH;
      hold  <= '0;
    end else if (accept) begin
      if (phase == PH_HIGH) begin
        hold  <= bus.byte_in;
        phase <= PH_LOW;
      end else begin
        phase <= PH_HIGH;
      end
    end
  end

  // NOTE: the storage array has no reset; count/pointers define which entries are valid.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {hold, bus.byte_in};
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

`ifdef HALT_OPCODE_EN
  logic halt_slot;
  logic run_q;

  assign skip_head = (head[15:12] == 4'hF);

  // halt_slot marks that the current ISSUE slot carries a halt opcode rather than a real issue.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      halt_slot <= 1'b0;
      run_q     <= 1'b0;
    end else begin
      run_q <= bus.run;
      if (load_instr) halt_slot <= skip_head;
    end
  end
`else
  assign skip_head = 1'b0;
`endif

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    next_state = state;
    load_instr = 1'b0;
    issue_en   = 1'b0;
    pop        = 1'b0;
    capture    = 1'b0;
    case (state)
      IDLE: begin
        if (bus.run && !empty) begin
          next_state = ISSUE;
          load_instr = 1'b1;
        end
      end
      ISSUE: begin
        pop = 1'b1;
`ifdef HALT_OPCODE_EN
        issue_en   = !halt_slot;
        next_state = halt_slot ? HALTED : WAIT;
`else
        issue_en   = 1'b1;
        next_state = WAIT;
`endif
      end
      WAIT: begin
        // The compute unit registered its result on the edge that ended ISSUE.
        capture = bus.cu_data_valid;
        if (bus.run && !empty) begin
          next_state = ISSUE;
          load_instr = 1'b1;
        end else begin
          next_state = IDLE;
        end
      end
`ifdef HALT_OPCODE_EN
      HALTED: begin
        if (bus.run && !run_q) next_state = IDLE;
      end
`endif
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state          <= IDLE;
      cu_instruction <= '0;
      retired        <= '0;
      result_data    <= '0;
      result_reg     <= '0;
      result_valid   <= 1'b0;
    end else begin
      state        <= next_state;
      result_valid <= capture;
      // Loaded on entry to ISSUE so the compute unit sees it for the whole ISSUE cycle.
      if (load_instr && !skip_head) cu_instruction <= head;
      if (issue_en) retired <= retired + 8'd1;
      if (capture) begin
        result_data <= bus.cu_data;
        result_reg  <= bus.cu_reg_id;
      end
    end
  end

  assign bus.cu_instruction = cu_instruction;
  assign bus.cu_en          = issue_en;
  assign bus.retired        = retired;
  assign bus.result_data    = result_data;
  assign bus.result_reg     = result_reg;
  assign bus.result_valid   = result_valid;
  assign bus.count          = count;
  assign bus.busy           = (state != IDLE) || !empty;

endmodule
